// File: rtl/aes_usb_pkg.sv
// Shared definitions for the AES/USB block datapath.
// Holds the block geometry and the state type used by the block-path FSMs.
// No ports (package).
package aes_usb_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);
    // One bit wider than the lane index so a full block (16) is representable.
    localparam int BYTES_W     = CNT_W + 1;

    typedef enum logic {
        FILL,
        FULL
    } asm_state_t;

endpackage

// File: rtl/plaintext_block_assembler_if.sv
// Bus bundle for plaintext_block_assembler: byte-FIFO read side, flush pulse,
// and the 128-bit block output handshake towards the AES core.
// Ports: none (interface). Modports:
//   slave  - the assembler: reads fifo_empty/fifo_r_data/flush/block_ready,
//            drives fifo_r_enable/block_data/block_valid/block_bytes/busy.
//   master - the surrounding logic (FIFO, AES core), opposite directions.
interface plaintext_block_assembler_if;
    import aes_usb_pkg::*;

    logic                 fifo_empty;
    logic [BYTE_W-1:0]    fifo_r_data;
    logic                 fifo_r_enable;
    logic                 flush;
    logic                 block_ready;
    logic [BLOCK_W-1:0]   block_data;
    logic                 block_valid;
    logic [BYTES_W-1:0]   block_bytes;
    logic                 busy;

    modport slave (
        input  fifo_empty, fifo_r_data, flush, block_ready,
        output fifo_r_enable, block_data, block_valid, block_bytes, busy
    );

    modport master (
        output fifo_empty, fifo_r_data, flush, block_ready,
        input  fifo_r_enable, block_data, block_valid, block_bytes, busy
    );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover value and synchronous clear.
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   clear_i           synchronous clear to 0 (wins over count_enable_i)
//   count_enable_i    advance by one this edge
//   rollover_val_i    last value before wrapping back to 0
//   count_o           current count
//   rollover_flag_o   count_o equals rollover_val_i
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o,
    output logic                    rollover_flag_o
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o         = count_q;
    assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/plaintext_block_assembler.sv
// Packs plaintext bytes popped from a byte FIFO into 128-bit blocks for the
// AES core. Byte 0 of a block lands in bits [7:0], byte 15 in [127:120].
// A flush pulse zero-pads and releases a partial block.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   bus          plaintext_block_assembler_if.slave:
//                  fifo_empty/fifo_r_data in, fifo_r_enable out (pop),
//                  flush in, block_ready in,
//                  block_data/block_valid/block_bytes out, busy out
module plaintext_block_assembler
    import aes_usb_pkg::*;
(
    input  logic                        clk,
    input  logic                        n_rst,
    plaintext_block_assembler_if.slave  bus
);

    asm_state_t           state_q, state_d;
    logic [BLOCK_W-1:0]   asm_q, asm_d;
    logic [BYTES_W-1:0]   asm_bytes_q, asm_bytes_d;
    logic [BLOCK_W-1:0]   out_data_q, out_data_d;
    logic [BYTES_W-1:0]   out_bytes_q, out_bytes_d;
    logic                 out_valid_q, out_valid_d;

    logic [CNT_W-1:0]     cnt;
    logic                 cnt_last;
    logic                 pop;
    logic                 xfer;

    // Pop whenever assembling and the FIFO has a byte; data is captured at
    // the same edge as the pop.
    assign pop  = (state_q == FILL) && !bus.fifo_empty;
    // A held block may move to the output when the slot is free or is being
    // accepted this edge, which keeps block_valid high back to back.
    assign xfer = (state_q == FULL) && (!out_valid_q || bus.block_ready);

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (xfer),
        .count_enable_i  (pop),
        .rollover_val_i  (CNT_W'(BLOCK_BYTES - 1)),
        .count_o         (cnt),
        .rollover_flag_o (cnt_last)
    );

    // Assembly FSM next state
    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        asm_bytes_d = asm_bytes_q;

        case (state_q)
            FILL: begin
                if (pop) begin
                    asm_d[BYTE_W*cnt +: BYTE_W] = bus.fifo_r_data;
                end
                if (pop && cnt_last) begin
                    state_d     = FULL;
                    asm_bytes_d = BYTES_W'(BLOCK_BYTES);
                end else if (bus.flush && ((cnt != '0) || pop)) begin
                    // Unfilled lanes are already zero from the last clear.
                    state_d     = FULL;
                    asm_bytes_d = {1'b0, cnt} + BYTES_W'(pop);
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d = FILL;
                    asm_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output register next state
    always_comb begin
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = asm_q;
            out_bytes_d = asm_bytes_q;
            out_valid_d = 1'b1;
        end else if (bus.block_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= FILL;
            asm_q       <= '0;
            asm_bytes_q <= '0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            asm_bytes_q <= asm_bytes_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.fifo_r_enable = pop;
    assign bus.block_data    = out_data_q;
    assign bus.block_bytes   = out_bytes_q;
    assign bus.block_valid   = out_valid_q;
    assign bus.busy          = (cnt != '0) || (state_q == FULL) || out_valid_q;

endmodule

// File: tb/tb_plaintext_block_assembler.sv
// Directed bench for plaintext_block_assembler with a queue-backed byte FIFO.
module tb_plaintext_block_assembler;
    import aes_usb_pkg::*;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    plaintext_block_assembler_if bus();

    plaintext_block_assembler dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pops = 0;
    int         last_pop_cyc = 0;
    logic       hold_empty = 1'b0;
    logic [7:0] fq[$];

    localparam logic [127:0] BLK_00 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_10 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] BLK_20 = 128'h2F2E2D2C2B2A29282726252423222120;
    localparam logic [127:0] BLK_A0 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
    localparam logic [127:0] BLK_C0 = 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    endtask

    // One clock: present FIFO head, note whether the DUT pops, step past the
    // edge, then retire the popped byte from the model.
    task automatic cycle(input logic fl);
        logic pop_now;
        bus.flush       = fl;
        bus.fifo_empty  = (fq.size() == 0) || hold_empty;
        bus.fifo_r_data = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        pop_now = bus.fifo_r_enable && !bus.fifo_empty;
        if (bus.fifo_empty) check("no_pop_when_empty", bus.fifo_r_enable, 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        if (pop_now && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
            last_pop_cyc = cyc;
        end
        bus.flush = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.block_valid && n < budget) begin
            cycle(1'b0);
            n++;
        end
        check({tag, "_timeout"}, bus.block_valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        bus.block_ready = 1'b1;
        cycle(1'b0);
        check({tag, "_valid_drop"}, bus.block_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stable_err;
        int seen_valid;

        bus.fifo_empty  = 1'b1;
        bus.fifo_r_data = 8'h00;
        bus.flush       = 1'b0;
        bus.block_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.block_valid, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        check("rst_bytes", bus.block_bytes, 5'd0);
        check("rst_data",  bus.block_data, 128'h0);
        check("rst_ren_empty", bus.fifo_r_enable, 1'b0);
        bus.fifo_empty = 1'b0;
        #1;
        check("rst_ren_nonempty", bus.fifo_r_enable, 1'b1);
        bus.fifo_empty = 1'b1;
        n_rst = 1'b1;

        // Full block back to back
        bus.block_ready = 1'b1;
        push_seq(8'h00, 16);
        pops = 0;
        wait_valid("t1", 40);
        check("t1_pops", pops, 16);
        check("t1_latency", cyc, last_pop_cyc + 1);
        check("t1_data", bus.block_data, BLK_00);
        check("t1_bytes", bus.block_bytes, 5'd16);
        drain("t1");
        check("t1_idle_busy", bus.busy, 1'b0);

        // Stall with block_ready low, second block held in FULL
        bus.block_ready = 1'b0;
        push_seq(8'h10, 32);
        fq.push_back(8'h55);
        pops = 0;
        stable_err = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0);
            if (bus.block_valid && bus.block_data !== BLK_10) stable_err++;
        end
        check("t2_stable", stable_err, 0);
        check("t2_pops", pops, 32);
        check("t2_valid", bus.block_valid, 1'b1);
        check("t2_bytes", bus.block_bytes, 5'd16);
        check("t2_stall_ren", bus.fifo_r_enable, 1'b0);
        check("t2_busy", bus.busy, 1'b1);
        bus.block_ready = 1'b1;
        cycle(1'b0);
        check("t2_b2b_valid", bus.block_valid, 1'b1);
        check("t2_b2b_data", bus.block_data, BLK_20);
        check("t2_b2b_bytes", bus.block_bytes, 5'd16);
        cycle(1'b0);
        check("t2_accept_valid", bus.block_valid, 1'b0);
        check("t2_tail_pop", pops, 33);
        cycle(1'b1);
        wait_valid("t2_tail", 4);
        check("t2_tail_data", bus.block_data, 128'h55);
        check("t2_tail_bytes", bus.block_bytes, 5'd1);
        drain("t2");

        // Three bytes then flush
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
        fq.push_back(8'hCC);
        repeat (3) cycle(1'b0);
        cycle(1'b1);
        wait_valid("t3", 4);
        check("t3_data", bus.block_data, 128'hCCBBAA);
        check("t3_bytes", bus.block_bytes, 5'd3);
        drain("t3");

        // Flush coincident with the 5th pop
        push_seq(8'h01, 5);
        repeat (4) cycle(1'b0);
        cycle(1'b1);
        wait_valid("t4", 4);
        check("t4_data", bus.block_data, 128'h0504030201);
        check("t4_bytes", bus.block_bytes, 5'd5);
        drain("t4");

        // Flush with nothing assembled is dropped and not remembered
        cycle(1'b1);
        seen_valid = 0;
        repeat (3) begin
            cycle(1'b0);
            if (bus.block_valid) seen_valid++;
        end
        check("t4_empty_flush_valid", seen_valid, 0);
        check("t4_empty_flush_busy", bus.busy, 1'b0);
        fq.push_back(8'h77);
        repeat (2) cycle(1'b0);
        check("t4_no_latch_valid", bus.block_valid, 1'b0);
        check("t4_partial_busy", bus.busy, 1'b1);
        cycle(1'b1);
        wait_valid("t4b", 4);
        check("t4b_data", bus.block_data, 128'h77);
        check("t4b_bytes", bus.block_bytes, 5'd1);
        drain("t4b");

        // FIFO empty toggling every other cycle
        push_seq(8'hA0, 16);
        pops = 0;
        begin
            int n = 0;
            while (!bus.block_valid && n < 80) begin
                hold_empty = cyc[0];
                cycle(1'b0);
                n++;
            end
        end
        hold_empty = 1'b0;
        check("t5_timeout", bus.block_valid, 1'b1);
        check("t5_pops", pops, 16);
        check("t5_data", bus.block_data, BLK_A0);
        check("t5_bytes", bus.block_bytes, 5'd16);
        drain("t5");

        // Reset mid-operation with a held output block and a partial block
        bus.block_ready = 1'b0;
        push_seq(8'h30, 16);
        wait_valid("t6a", 40);
        push_seq(8'hE0, 7);
        repeat (7) cycle(1'b0);
        check("t6_pre_busy", bus.busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("t6_rst_valid", bus.block_valid, 1'b0);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_data", bus.block_data, 128'h0);
        #1;
        n_rst = 1'b1;
        bus.block_ready = 1'b1;
        push_seq(8'hC0, 16);
        wait_valid("t6", 40);
        check("t6_data", bus.block_data, BLK_C0);
        check("t6_bytes", bus.block_bytes, 5'd16);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
